// File: rtl/aes_pkg.sv
// Shared types and constants for the AES host-side sequencer.
// Holds the FSM state encoding, key-size codes and the key-word-count helper.
package aes_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_KEY   = 2'd1,
      ST_DATA  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   localparam logic [1:0] KSIZE_128  = 2'd0;
   localparam logic [1:0] KSIZE_192  = 2'd1;
   localparam logic [1:0] KSIZE_256  = 2'd2;
   localparam logic [1:0] KSIZE_RSVD = 2'd3;

   // Number of 32-bit key words for a key-size code; the reserved code never reaches KEY.
   function automatic logic [3:0] key_words(input logic [1:0] ksize);
      logic [3:0] n;
      n = 4'd4;
      case (ksize)
         KSIZE_128: n = 4'd4;
         KSIZE_192: n = 4'd6;
         KSIZE_256: n = 4'd8;
         default:   n = 4'd4;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/aes_obuf.sv
// Result buffer: synchronous FIFO with a combinational head and an occupancy count.
// A push into a full buffer is accepted only when a pop frees a slot in the same cycle.
module aes_obuf
   import aes_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       clear,
   input  logic                       push,
   input  logic                       pop,
   input  logic [31:0]                din,
   output logic [31:0]                dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE_COUNT  = (AW+1)'(1);

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          wr;
   logic          rd;

   assign full  = (count == FULL_COUNT);
   assign empty = (count == '0);
   assign dout  = mem[rd_ptr];
   assign wr    = push && (!full || pop);
   assign rd    = pop && !empty;

   // Storage carries no reset so it can map onto distributed RAM.
   always_ff @(posedge clk) begin
      if (wr && !clear) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({wr, rd})
            2'b10:   count <= count + ONE_COUNT;
            2'b01:   count <= count - ONE_COUNT;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/aes_seq.sv
// Host-side sequencer for the AES engine: loads the key, streams data words under a
// credit limit so results always fit the output buffer, and signals completion.
module aes_seq
   import aes_pkg::*;
#(
   parameter int OBUF_DEPTH = 8,
   parameter int NBLK_W     = 16
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              cmd_vld,
   output logic              cmd_rdy,
   input  logic [1:0]        cmd_ksize,
   input  logic [NBLK_W-1:0] cmd_nblk,
   input  logic              abort,
   input  logic              key_vld,
   output logic              key_rdy,
   input  logic [31:0]       key_data,
   input  logic              in_vld,
   output logic              in_rdy,
   input  logic [31:0]       in_data,
   output logic              out_vld,
   input  logic              out_rdy,
   output logic [31:0]       out_data,
   output logic              done,
   output logic              err,
   output logic              aes_en,
   output logic              aes_go,
   output logic [1:0]        aes_ksize,
   output logic [31:0]       aes_din,
   output logic [31:0]       aes_key,
   input  logic              aes_din_req,
   input  logic [31:0]       aes_dout,
   input  logic              aes_dout_vld
);

   localparam int CW = $clog2(OBUF_DEPTH) + 1;
   localparam int WW = NBLK_W + 2;
   localparam logic [CW-1:0] CREDIT_FULL = CW'(OBUF_DEPTH);
   localparam logic [CW-1:0] CREDIT_ONE  = CW'(1);
   localparam logic [CW:0]   SLOTS_TOTAL = (CW+1)'(OBUF_DEPTH);

   state_t            state;
   state_t            state_nxt;
   logic [NBLK_W-1:0] nblk;
   logic [3:0]        key_cnt;
   logic [WW-1:0]     words_sent;
   logic [WW-1:0]     words_popped;
   logic [WW-1:0]     popped_nxt;
   logic [WW-1:0]     total_words;
   logic [CW-1:0]     credit;
   logic [CW-1:0]     obuf_count;
   logic              obuf_full;
   logic              obuf_empty;
   logic              cmd_acc;
   logic              key_acc;
   logic              in_acc;
   logic              out_pop;
   logic              push;
   logic              overrun;
   logic              credit_room;
   logic              go_set;
   logic              done_set;

   assign total_words = {nblk, 2'b00};
   assign cmd_rdy     = (state == ST_IDLE) && !abort;
   assign key_rdy     = (state == ST_KEY) && !abort && (key_cnt != key_words(aes_ksize));
   assign in_rdy      = (state == ST_DATA) && !abort && aes_din_req
                        && (credit != '0) && (words_sent < total_words);
   assign out_vld     = !obuf_empty;
   assign cmd_acc     = cmd_vld && cmd_rdy;
   assign key_acc     = key_vld && key_rdy;
   assign in_acc      = in_vld && in_rdy;
   assign out_pop     = out_vld && out_rdy;
   assign push        = aes_dout_vld && (state != ST_IDLE);
   assign overrun     = push && obuf_full && !out_pop && !abort;
   assign popped_nxt  = words_popped + WW'(out_pop);

   // A pop returns a credit only while credits plus buffered words stay within the
   // buffer, so stray engine words can never inflate the credit pool.
   assign credit_room = ({1'b0, credit} + {1'b0, obuf_count}) <= SLOTS_TOTAL;

   aes_obuf #(
      .DEPTH (OBUF_DEPTH)
   ) u_obuf (
      .clk   (clk),
      .rstn  (rstn),
      .clear (abort),
      .push  (push),
      .pop   (out_pop),
      .din   (aes_dout),
      .dout  (out_data),
      .full  (obuf_full),
      .empty (obuf_empty),
      .count (obuf_count)
   );

   // Next-state logic; abort overrides every other transition and suppresses pulses.
   always_comb begin
      state_nxt = state;
      go_set    = 1'b0;
      done_set  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (cmd_acc) begin
               if (cmd_ksize == KSIZE_RSVD) begin
                  done_set = 1'b1;
               end else begin
                  state_nxt = ST_KEY;
               end
            end
         end
         ST_KEY: begin
            if (key_cnt == key_words(aes_ksize)) begin
               go_set = 1'b1;
               if (nblk == '0) begin
                  done_set  = 1'b1;
                  state_nxt = ST_IDLE;
               end else begin
                  state_nxt = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (words_sent == total_words) begin
               state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (popped_nxt == total_words) begin
               done_set  = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (abort) begin
         state_nxt = ST_IDLE;
         go_set    = 1'b0;
         done_set  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state        <= ST_IDLE;
         done         <= 1'b0;
         aes_go       <= 1'b0;
         aes_en       <= 1'b0;
         aes_din      <= '0;
         aes_key      <= '0;
         aes_ksize    <= '0;
         nblk         <= '0;
         err          <= 1'b0;
         key_cnt      <= '0;
         words_sent   <= '0;
         words_popped <= '0;
         credit       <= CREDIT_FULL;
      end else begin
         state  <= state_nxt;
         done   <= done_set;
         aes_go <= go_set;
         aes_en <= in_acc;
         if (in_acc) begin
            aes_din <= in_data;
         end
         if (key_acc) begin
            aes_key <= key_data;
         end

         if (cmd_acc) begin
            aes_ksize <= cmd_ksize;
            nblk      <= cmd_nblk;
            err       <= (cmd_ksize == KSIZE_RSVD);
         end else if (overrun) begin
            err <= 1'b1;
         end

         if (abort || cmd_acc) begin
            key_cnt      <= '0;
            words_sent   <= '0;
            words_popped <= '0;
         end else begin
            if (key_acc) begin
               key_cnt <= key_cnt + 4'd1;
            end
            if (in_acc) begin
               words_sent <= words_sent + WW'(1);
            end
            words_popped <= popped_nxt;
         end

         if (abort) begin
            credit <= CREDIT_FULL;
         end else begin
            case ({in_acc, out_pop})
               2'b10:   credit <= credit - CREDIT_ONE;
               2'b01:   credit <= credit_room ? credit + CREDIT_ONE : credit;
               default: credit <= credit;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_aes_seq.sv
// Self-checking bench for aes_seq: random key/data/handshake traffic against a
// queue-based model of the command, with a two-cycle din^key engine stand-in.
module tb_aes_seq;

   logic        clk = 1'b0;
   logic        rstn;
   logic        cmd_vld;
   logic        cmd_rdy;
   logic [1:0]  cmd_ksize;
   logic [15:0] cmd_nblk;
   logic        abort;
   logic        key_vld;
   logic        key_rdy;
   logic [31:0] key_data;
   logic        in_vld;
   logic        in_rdy;
   logic [31:0] in_data;
   logic        out_vld;
   logic        out_rdy;
   logic [31:0] out_data;
   logic        done;
   logic        err;
   logic        aes_en;
   logic        aes_go;
   logic [1:0]  aes_ksize;
   logic [31:0] aes_din;
   logic [31:0] aes_key;
   logic        aes_din_req;
   logic [31:0] aes_dout;
   logic        aes_dout_vld;
   logic        inject;
   logic        e1_v, e2_v;
   logic [31:0] e1_d, e2_d;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   aes_seq dut (
      .clk          (clk),
      .rstn         (rstn),
      .cmd_vld      (cmd_vld),
      .cmd_rdy      (cmd_rdy),
      .cmd_ksize    (cmd_ksize),
      .cmd_nblk     (cmd_nblk),
      .abort        (abort),
      .key_vld      (key_vld),
      .key_rdy      (key_rdy),
      .key_data     (key_data),
      .in_vld       (in_vld),
      .in_rdy       (in_rdy),
      .in_data      (in_data),
      .out_vld      (out_vld),
      .out_rdy      (out_rdy),
      .out_data     (out_data),
      .done         (done),
      .err          (err),
      .aes_en       (aes_en),
      .aes_go       (aes_go),
      .aes_ksize    (aes_ksize),
      .aes_din      (aes_din),
      .aes_key      (aes_key),
      .aes_din_req  (aes_din_req),
      .aes_dout     (aes_dout),
      .aes_dout_vld (aes_dout_vld)
   );

   // Engine stand-in: result is din^key, valid two cycles after aes_en.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         e1_v <= 1'b0; e2_v <= 1'b0; e1_d <= '0; e2_d <= '0;
      end else begin
         e1_v <= aes_en; e1_d <= aes_din ^ aes_key;
         e2_v <= e1_v;   e2_d <= e1_d;
      end
   end
   assign aes_dout_vld = e2_v | inject;
   assign aes_dout     = inject ? 32'hDEAD_BEEF : e2_d;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic idleInputs();
      cmd_vld = 0; cmd_ksize = 0; cmd_nblk = 0; abort = 0;
      key_vld = 0; key_data = 0; in_vld = 0; in_data = 0;
      out_rdy = 0; aes_din_req = 1; inject = 0;
   endtask

   // One full command against the model; stall holds out_rdy low until the buffer fills.
   task automatic applyStimulus(input logic [1:0] ks, input int nb, input bit stall,
                                input bit do_inject, input bit rnd);
      int kw = 4 + 2 * int'(ks);
      int total = 4 * nb;
      int lim = (total < 8) ? total : 8;
      logic [31:0] keys [8];
      logic [31:0] exp_q [$];
      logic [31:0] next_din;
      int kidx = 0, sent = 0, popped = 0, go_cnt = 0, done_cnt = 0, en_cnt = 0;
      int go_cyc = -1, last_key_cyc = -1, last_pop_cyc = -1, done_cyc = -1;
      int quiet = 0;
      int ph = stall ? 0 : 3;
      for (int i = 0; i < 8; i++) keys[i] = $urandom;
      next_din = $urandom;

      @(negedge clk);
      cmd_vld = 1; cmd_ksize = ks; cmd_nblk = 16'(nb);
      #1 checkOutput("cmd_rdy", {31'd0, cmd_rdy}, 1);

      for (int c = 0; c < 3000 && done_cnt == 0; c++) begin
         @(negedge clk);
         cmd_vld  = 0;
         key_vld  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         key_data = (kidx < kw) ? keys[kidx] : $urandom;
         in_vld   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         in_data  = next_din;
         aes_din_req = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         out_rdy  = (ph == 3) ? (rnd ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
         inject   = (ph == 1);
         #1;
         if (c == 0) begin
            checkOutput("ksize_hold", {30'd0, aes_ksize}, {30'd0, ks});
            checkOutput("err_clear", {31'd0, err}, 0);
         end
         if (key_vld && key_rdy) begin
            kidx++;
            last_key_cyc = c;
         end
         if (in_vld && in_rdy) begin
            checkOutput("credit_bound", 32'((sent - popped) < 8), 1);
            exp_q.push_back(next_din ^ keys[kw-1]);
            sent++;
            next_din = $urandom;
         end
         if (out_vld && out_rdy) begin
            if (exp_q.size() == 0) checkOutput("extra_out", out_data, 32'hFFFF_FFFF ^ out_data);
            else checkOutput("out_data", out_data, exp_q.pop_front());
            popped++;
            last_pop_cyc = c;
         end
         if (aes_go) begin
            go_cnt++;
            go_cyc = c;
            checkOutput("go_key", aes_key, keys[kw-1]);
         end
         if (aes_en) en_cnt++;
         if (done) begin
            done_cnt++;
            done_cyc = c;
         end
         case (ph)
            0: if (sent == lim) begin
                  quiet++;
                  if (quiet == 6) begin
                     checkOutput("stall_in_rdy", {31'd0, in_rdy}, 0);
                     checkOutput("stall_err", {31'd0, err}, 0);
                     checkOutput("stall_out_vld", {31'd0, out_vld}, 1);
                     ph = do_inject ? 1 : 3;
                  end
               end
            1: ph = 2;
            2: begin
                  checkOutput("ovr_err", {31'd0, err}, 1);
                  checkOutput("ovr_out_vld", {31'd0, out_vld}, 1);
                  ph = 3;
               end
            default: ;
         endcase
      end

      checkOutput("done_seen", done_cnt, 1);
      checkOutput("key_words", kidx, kw);
      checkOutput("go_count", go_cnt, 1);
      checkOutput("go_timing", go_cyc, last_key_cyc + 2);
      checkOutput("words_sent", sent, total);
      checkOutput("words_out", popped, total);
      checkOutput("en_count", en_cnt, total);
      if (total == 0) checkOutput("done_timing", done_cyc, go_cyc);
      else            checkOutput("done_timing", done_cyc, last_pop_cyc + 1);

      @(negedge clk);
      key_vld = 0; in_vld = 0; out_rdy = 0; inject = 0;
      #1;
      checkOutput("done_pulse", {31'd0, done}, 0);
      checkOutput("end_cmd_rdy", {31'd0, cmd_rdy}, 1);
      checkOutput("end_err", {31'd0, err}, {31'd0, do_inject});
      checkOutput("end_out_vld", {31'd0, out_vld}, 0);
   endtask

   task automatic reservedCmd();
      @(negedge clk);
      cmd_vld = 1; cmd_ksize = 2'd3; cmd_nblk = 16'd2;
      #1 checkOutput("rsvd_cmd_rdy", {31'd0, cmd_rdy}, 1);
      @(negedge clk);
      cmd_vld = 0;
      #1;
      checkOutput("rsvd_err", {31'd0, err}, 1);
      checkOutput("rsvd_done", {31'd0, done}, 1);
      checkOutput("rsvd_key_rdy", {31'd0, key_rdy}, 0);
      @(negedge clk);
      #1;
      checkOutput("rsvd_done_pulse", {31'd0, done}, 0);
      checkOutput("rsvd_err_sticky", {31'd0, err}, 1);
      checkOutput("rsvd_idle_key_rdy", {31'd0, key_rdy}, 0);
   endtask

   task automatic abortTest();
      int pushes = 0;
      @(negedge clk);
      cmd_vld = 1; cmd_ksize = 2'd0; cmd_nblk = 16'd4;
      #1 checkOutput("abort_cmd_rdy", {31'd0, cmd_rdy}, 1);
      for (int c = 0; c < 200 && pushes < 3; c++) begin
         @(negedge clk);
         cmd_vld = 0; key_vld = 1; key_data = $urandom;
         in_vld = 1; in_data = $urandom; out_rdy = 0; aes_din_req = 1;
         #1;
         if (aes_dout_vld) pushes++;
      end
      checkOutput("abort_setup", pushes, 3);
      @(negedge clk);
      abort = 1; key_vld = 0; in_vld = 0;
      #1 checkOutput("abort_buffered", {31'd0, out_vld}, 1);
      @(negedge clk);
      abort = 0;
      #1;
      checkOutput("abort_out_vld", {31'd0, out_vld}, 0);
      checkOutput("abort_cmd_rdy_after", {31'd0, cmd_rdy}, 1);
      checkOutput("abort_no_done", {31'd0, done}, 0);
      checkOutput("abort_en", {31'd0, aes_en}, 0);
      checkOutput("abort_err", {31'd0, err}, 0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         #1 checkOutput("abort_quiet_done", {31'd0, done | out_vld}, 0);
      end
   endtask

   initial begin
      #3_000_000;
      $display("[TB] FAIL watchdog got=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      idleInputs();
      rstn = 0;
      repeat (3) @(negedge clk);
      #1;
      checkOutput("rst_cmd_rdy", {31'd0, cmd_rdy}, 1);
      checkOutput("rst_key_rdy", {31'd0, key_rdy}, 0);
      checkOutput("rst_in_rdy", {31'd0, in_rdy}, 0);
      checkOutput("rst_out_vld", {31'd0, out_vld}, 0);
      checkOutput("rst_flags", {28'd0, done, err, aes_en, aes_go}, 0);
      checkOutput("rst_key", aes_key, 0);
      @(negedge clk);
      rstn = 1;

      applyStimulus(2'd0, 2, 1'b0, 1'b0, 1'b0);
      applyStimulus(2'd2, 1, 1'b0, 1'b0, 1'b1);
      applyStimulus(2'd0, 4, 1'b1, 1'b0, 1'b0);
      reservedCmd();
      applyStimulus(2'd1, 3, 1'b0, 1'b0, 1'b1);
      abortTest();
      repeat (3) @(negedge clk);
      applyStimulus(2'd0, 1, 1'b0, 1'b0, 1'b0);
      applyStimulus(2'd0, 4, 1'b1, 1'b1, 1'b0);
      applyStimulus(2'd2, 0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(2'($urandom_range(0, 2)), $urandom_range(1, 5), 1'b0, 1'b0, 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
